jtag_bus_master: RTL and testbench



---
 rtl/jtag_bus_pkg.sv | 24 ++
 rtl/generic_bus_if.sv | 15 +
 rtl/bus_timeout_counter.sv | 33 +++
 rtl/jtag_bus_master.sv | 153 +++++++++++++++
 tb/tb_jtag_bus_master.sv | 515 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/jtag_bus_pkg.sv
// Shared types and defaults for the JTAG-driven bus master.
//   state_t : FSM states of jtag_bus_master
//   cmd_t   : one command word as seen from the JTAG data-register side
package jtag_bus_pkg;

  localparam int unsigned DEF_CNT_W          = 8;
  localparam int unsigned DEF_ADDR_INC       = 4;
  localparam int unsigned DEF_TIMEOUT_CYCLES = 256;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RSP  = 2'd2
  } state_t;

  typedef struct packed {
    logic                 write;
    logic [31:0]          addr;
    logic [31:0]          wdata;
    logic [3:0]           byte_en;
    logic [DEF_CNT_W-1:0] len;
  } cmd_t;

endpackage

// File: rtl/generic_bus_if.sv
// Generic single-master memory bus.
//   cpu modport : drives addr, wdata, ren, wen, byte_en; samples rdata, busy
//   mem modport : the slave view of the same wires
interface generic_bus_if;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ren;
  logic        wen;
  logic [3:0]  byte_en;
  logic        busy;

  modport cpu (output addr, wdata, ren, wen, byte_en, input rdata, busy);
  modport mem (input addr, wdata, ren, wen, byte_en, output rdata, busy);
endinterface

// File: rtl/bus_timeout_counter.sv
// Per-beat busy timer.
//   CLK, RST : clock, synchronous active-high reset
//   clear    : reload for a fresh beat (has priority over enable)
//   enable   : count one busy cycle
//   expired  : the current cycle is the TIMEOUT_CYCLES-th busy cycle of the beat
module bus_timeout_counter #(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic CLK,
  input  logic RST,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  // Loaded with one less than the limit so the terminal count coincides
  // with the last tolerated busy cycle rather than the one after it.
  localparam logic [TW-1:0] LOAD = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] cnt;

  always_ff @(posedge CLK) begin
    if (RST || clear) begin
      cnt <= LOAD;
    end else if (enable && (cnt != '0)) begin
      cnt <= cnt - TW'(1);
    end
  end

  assign expired = (cnt == '0);

endmodule

// File: rtl/jtag_bus_master.sv
// Turns JTAG command words into single or auto-incrementing burst accesses
// on the generic bus, with a response handshake and a per-beat busy timeout.
//   CLK, RST      : clock, synchronous active-high reset
//   cmd_*         : command handshake (write, start addr, fill data, byte enables, beats-1)
//   rsp_*         : response handshake (read data, timeout error, last of command)
//   gbus          : generic_bus_if cpu modport
//
// state | meaning
// IDLE  | waiting for a command, cmd_ready high
// BUS   | beat in flight, ren or wen held until busy drops or the timer expires
// RSP   | response offered, bus quiet until rsp_ready
module jtag_bus_master import jtag_bus_pkg::*; #(
  parameter int unsigned CNT_W          = DEF_CNT_W,
  parameter int unsigned ADDR_INC       = DEF_ADDR_INC,
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_write,
  input  logic [31:0]      cmd_addr,
  input  logic [31:0]      cmd_wdata,
  input  logic [3:0]       cmd_byte_en,
  input  logic [CNT_W-1:0] cmd_len,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_rdata,
  output logic             rsp_err,
  output logic             rsp_last,
  generic_bus_if.cpu       gbus
);

  state_t           state, state_next;
  logic             write_q;
  logic [31:0]      addr_q;
  logic [31:0]      wdata_q;
  logic [3:0]       byte_en_q;
  logic [CNT_W-1:0] remaining_q;
  logic             err_q;
  logic [31:0]      rdata_q;

  logic accept, beat_done, timeout, advance;
  logic tmr_clear, tmr_enable, tmr_expired;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    beat_done  = 1'b0;
    timeout    = 1'b0;
    advance    = 1'b0;
    case (state)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          accept     = 1'b1;
          state_next = BUS;
        end
      end
      BUS: begin
        // A beat finishing on the expiry cycle wins over the timeout.
        if (!gbus.busy) begin
          beat_done = 1'b1;
          if (write_q && (remaining_q != '0)) begin
            advance = 1'b1;
          end else begin
            state_next = RSP;
          end
        end else if (tmr_expired) begin
          timeout    = 1'b1;
          state_next = RSP;
        end
      end
      RSP: begin
        if (rsp_ready) begin
          if (rsp_last) begin
            state_next = IDLE;
          end else begin
            advance    = 1'b1;
            state_next = BUS;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      write_q     <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      byte_en_q   <= '0;
      remaining_q <= '0;
      err_q       <= 1'b0;
      rdata_q     <= '0;
    end else begin
      if (accept) begin
        write_q     <= cmd_write;
        addr_q      <= cmd_addr;
        wdata_q     <= cmd_wdata;
        byte_en_q   <= cmd_byte_en;
        remaining_q <= cmd_len;
        err_q       <= 1'b0;
        rdata_q     <= '0;
      end
      if (advance) begin
        addr_q      <= addr_q + 32'(ADDR_INC);
        remaining_q <= remaining_q - CNT_W'(1);
      end
      if (beat_done) begin
        rdata_q <= write_q ? '0 : gbus.rdata;
      end
      if (timeout) begin
        err_q   <= 1'b1;
        rdata_q <= '0;
      end
    end
  end

  assign tmr_clear  = (state != BUS) || beat_done;
  assign tmr_enable = (state == BUS) && gbus.busy;

  bus_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .CLK    (CLK),
    .RST    (RST),
    .clear  (tmr_clear),
    .enable (tmr_enable),
    .expired(tmr_expired)
  );

  // cmd_ready is gated by RST directly so it is low for the whole reset pulse.
  assign cmd_ready    = (state == IDLE) && !RST;
  assign gbus.ren     = (state == BUS) && !write_q;
  assign gbus.wen     = (state == BUS) && write_q;
  assign gbus.addr    = addr_q;
  assign gbus.wdata   = wdata_q;
  assign gbus.byte_en = byte_en_q;
  assign rsp_valid    = (state == RSP);
  assign rsp_rdata    = rdata_q;
  assign rsp_err      = (state == RSP) && err_q;
  assign rsp_last     = (state == RSP) && (err_q || (remaining_q == '0));

endmodule

// File: tb/tb_jtag_bus_master.sv
module tb_jtag_bus_master;
  import jtag_bus_pkg::*;

  localparam int TO = 8;

  typedef struct packed {
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } beat_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
    logic        last;
  } rsp_t;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_byte_en;
  logic [7:0]  cmd_len;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        rsp_last;

  generic_bus_if gbus ();

  jtag_bus_master #(
    .CNT_W         (8),
    .ADDR_INC      (4),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_write  (cmd_write),
    .cmd_addr   (cmd_addr),
    .cmd_wdata  (cmd_wdata),
    .cmd_byte_en(cmd_byte_en),
    .cmd_len    (cmd_len),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .rsp_last   (rsp_last),
    .gbus       (gbus)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  beat_t got_b[$];
  beat_t exp_b[$];
  rsp_t  got_r[$];
  rsp_t  exp_r[$];
  int    wait_q[$];
  int    waits_m[$];
  int    bp_delay = 0;
  int    exp_bus, bus_cyc, both_hi, unstable, overlap, hold_cyc;
  int    cyc = 0;
  int    first_act, last_act;
  logic [31:0] mem [logic [31:0]];

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  // Slave and response-consumer: react 1 time unit after each rising edge.
  bit in_beat = 0;
  int waited = 0;
  int target = 0;
  int hold_n = 0;
  always @(posedge CLK) begin
    #1;
    if (RST || !(gbus.ren || gbus.wen)) begin
      gbus.busy = 1'b0;
      in_beat   = 0;
    end else begin
      if (!in_beat) begin
        in_beat = 1;
        waited  = 0;
        target  = 0;
        if (wait_q.size() > 0) target = wait_q.pop_front();
      end
      if (waited < target) begin
        gbus.busy  = 1'b1;
        gbus.rdata = 32'hBAD0_BAD0;
        waited++;
      end else begin
        gbus.busy  = 1'b0;
        gbus.rdata = mem_rd(gbus.addr);
        in_beat    = 0;
      end
    end
    if (rsp_valid) begin
      if (hold_n >= bp_delay) rsp_ready = 1'b1;
      else begin
        rsp_ready = 1'b0;
        hold_n++;
      end
    end else begin
      rsp_ready = 1'b0;
      hold_n    = 0;
    end
  end

  // Monitor on the falling edge.
  bit   hold_prev = 0;
  rsp_t prev_rsp;
  always @(negedge CLK) begin
    cyc++;
    if (!RST) begin
      if (gbus.ren && gbus.wen) both_hi++;
      if (gbus.ren || gbus.wen) begin
        bus_cyc++;
        if (first_act < 0) first_act = cyc;
        last_act = cyc;
        if (rsp_valid) overlap++;
        if (!gbus.busy)
          got_b.push_back(beat_t'({gbus.wen, gbus.addr, gbus.wen ? gbus.wdata : 32'h0, gbus.byte_en}));
      end
      if (rsp_valid && rsp_ready) got_r.push_back(rsp_t'({rsp_rdata, rsp_err, rsp_last}));
      if (rsp_valid && !rsp_ready) hold_cyc++;
      if (hold_prev && !(rsp_valid && (rsp_t'({rsp_rdata, rsp_err, rsp_last}) == prev_rsp))) unstable++;
      hold_prev = rsp_valid && !rsp_ready;
      prev_rsp  = rsp_t'({rsp_rdata, rsp_err, rsp_last});
    end else begin
      hold_prev = 0;
    end
  end

  // Reference: beat i targets addr+4*i; the first beat whose slave wait reaches
  // TO busy cycles is aborted with an error response and ends the command.
  task automatic build_expect(input cmd_t c);
    logic [31:0] a;
    int w;
    exp_b.delete();
    exp_r.delete();
    exp_bus = 0;
    for (int i = 0; i <= int'(c.len); i++) begin
      a = c.addr + 32'(i) * 32'd4;
      w = (i < waits_m.size()) ? waits_m[i] : 0;
      if (w >= TO) begin
        exp_bus += TO;
        exp_r.push_back(rsp_t'({32'h0, 1'b1, 1'b1}));
        return;
      end
      exp_bus += w + 1;
      exp_b.push_back(beat_t'({c.write, a, c.write ? c.wdata : 32'h0, c.byte_en}));
      if (!c.write) exp_r.push_back(rsp_t'({mem_rd(a), 1'b0, i == int'(c.len)}));
    end
    if (c.write) exp_r.push_back(rsp_t'({32'h0, 1'b0, 1'b1}));
  endtask

  task automatic run_cmd(input cmd_t c, input int bp, input bit junk);
    int n;
    got_b.delete();
    got_r.delete();
    bus_cyc = 0; both_hi = 0; unstable = 0; overlap = 0; hold_cyc = 0; first_act = -1;
    wait_q   = waits_m;
    bp_delay = bp;
    build_expect(c);
    n = 0;
    while (!cmd_ready && n < 100) begin
      @(negedge CLK);
      n++;
    end
    if (!cmd_ready) begin
      checks++; errors++;
      $display("FAIL cmd_accept: cmd_ready=0, want 1 within 100 cycles");
      return;
    end
    cmd_valid   = 1'b1;
    cmd_write   = c.write;
    cmd_addr    = c.addr;
    cmd_wdata   = c.wdata;
    cmd_byte_en = c.byte_en;
    cmd_len     = c.len;
    @(posedge CLK);
    #1;
    if (junk) begin
      cmd_write = ~c.write;
      cmd_addr  = 32'hBADC_0DE0;
      cmd_len   = 8'd7;
    end else begin
      cmd_valid = 1'b0;
    end
    n = 0;
    while (got_r.size() < exp_r.size() && n < 500) begin
      @(negedge CLK);
      if (junk && rsp_valid && rsp_ready && rsp_last) cmd_valid = 1'b0;
      n++;
    end
    cmd_valid = 1'b0;
    if (n >= 500) begin
      checks++; errors++;
      $display("FAIL rsp_wait: got %0d responses, want %0d within 500 cycles", got_r.size(), exp_r.size());
    end
    repeat (4) @(negedge CLK);
  endtask

  task automatic test_reset();
    RST = 1'b1;
    repeat (3) @(negedge CLK);
    checks++;
    if ({cmd_ready, gbus.ren, gbus.wen, rsp_valid, rsp_err, rsp_last} !== 6'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got rdy,ren,wen,vld,err,last=%b want 000000",
               {cmd_ready, gbus.ren, gbus.wen, rsp_valid, rsp_err, rsp_last});
    end
    checks++;
    if ({rsp_rdata, gbus.addr, gbus.wdata, gbus.byte_en} !== 100'b0) begin
      errors++;
      $display("FAIL reset_data: got rdata=%h addr=%h wdata=%h be=%h want all 0",
               rsp_rdata, gbus.addr, gbus.wdata, gbus.byte_en);
    end
    RST = 1'b0;
    @(negedge CLK);
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready: got %b want 1", cmd_ready);
    end
  endtask

  task automatic test_single_read();
    cmd_t c;
    mem[32'h100] = 32'hDEAD_BEEF;
    c = '{write: 1'b0, addr: 32'h100, wdata: 32'h0, byte_en: 4'hF, len: 8'd0};
    waits_m = '{3};
    run_cmd(c, 0, 0);
    checks++;
    if (bus_cyc != 4) begin
      errors++;
      $display("FAIL single_ren_cycles: got %0d want 4", bus_cyc);
    end
    checks++;
    if (got_r.size() != 1) begin
      errors++;
      $display("FAIL single_rsp_count: got %0d want 1", got_r.size());
    end else begin
      checks++;
      if (got_r[0] !== rsp_t'({32'hDEAD_BEEF, 1'b0, 1'b1})) begin
        errors++;
        $display("FAIL single_rsp: got rdata=%h err=%b last=%b want deadbeef 0 1",
                 got_r[0].rdata, got_r[0].err, got_r[0].last);
      end
    end
  endtask

  task automatic test_write_fill();
    cmd_t c;
    c = '{write: 1'b1, addr: 32'h200, wdata: 32'hA5A5_A5A5, byte_en: 4'hF, len: 8'd3};
    waits_m = '{0, 0, 0, 0};
    run_cmd(c, 0, 0);
    checks++;
    if (got_b.size() != 4) begin
      errors++;
      $display("FAIL fill_beat_count: got %0d want 4", got_b.size());
    end
    for (int i = 0; i < exp_b.size() && i < got_b.size(); i++) begin
      checks++;
      if (got_b[i] !== exp_b[i]) begin
        errors++;
        $display("FAIL fill_beat[%0d]: got a=%h d=%h be=%h w=%b want a=%h d=%h be=%h w=%b", i,
                 got_b[i].addr, got_b[i].wdata, got_b[i].be, got_b[i].write,
                 exp_b[i].addr, exp_b[i].wdata, exp_b[i].be, exp_b[i].write);
      end
    end
    checks++;
    if (bus_cyc != 4 || (last_act - first_act + 1) != 4) begin
      errors++;
      $display("FAIL fill_back_to_back: got %0d wen cycles over span %0d want 4 over 4",
               bus_cyc, last_act - first_act + 1);
    end
    checks++;
    if (got_r.size() != 1 || got_r[0] !== rsp_t'({32'h0, 1'b0, 1'b1})) begin
      errors++;
      $display("FAIL fill_rsp: got %0d responses (first=%h) want 1 with rdata 0 err 0 last 1",
               got_r.size(), (got_r.size() > 0) ? got_r[0] : rsp_t'(0));
    end
  endtask

  task automatic test_read_backpressure();
    cmd_t c;
    c = '{write: 1'b0, addr: 32'h1000 + ($urandom_range(0, 255) << 2), wdata: $urandom(),
          byte_en: 4'(($urandom_range(1, 15))), len: 8'd2};
    waits_m = '{$urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3)};
    run_cmd(c, 5, 0);
    checks++;
    if (got_r.size() != 3) begin
      errors++;
      $display("FAIL bp_rsp_count: got %0d want 3", got_r.size());
    end
    for (int i = 0; i < exp_r.size() && i < got_r.size(); i++) begin
      checks++;
      if (got_r[i] !== exp_r[i]) begin
        errors++;
        $display("FAIL bp_rsp[%0d]: got rdata=%h err=%b last=%b want rdata=%h err=%b last=%b", i,
                 got_r[i].rdata, got_r[i].err, got_r[i].last, exp_r[i].rdata, exp_r[i].err, exp_r[i].last);
      end
    end
    checks++;
    if (hold_cyc != 15 || unstable != 0) begin
      errors++;
      $display("FAIL bp_hold: got %0d stalled cycles, %0d unstable want 15, 0", hold_cyc, unstable);
    end
    checks++;
    if (overlap != 0 || bus_cyc != exp_bus) begin
      errors++;
      $display("FAIL bp_bus_quiet: got overlap=%0d bus_cycles=%0d want 0, %0d", overlap, bus_cyc, exp_bus);
    end
  endtask

  task automatic test_timeout();
    cmd_t c;
    int w0;
    w0 = $urandom_range(0, 3);
    c = '{write: 1'b0, addr: 32'h3000, wdata: 32'h0, byte_en: 4'hF, len: 8'd3};
    waits_m = '{w0, 1000, 0, 0};
    run_cmd(c, 1, 0);
    checks++;
    if (bus_cyc != w0 + 1 + TO || got_b.size() != 1) begin
      errors++;
      $display("FAIL to_bus: got %0d ren cycles, %0d beats want %0d, 1", bus_cyc, got_b.size(), w0 + 1 + TO);
    end
    checks++;
    if (got_r.size() != 2) begin
      errors++;
      $display("FAIL to_rsp_count: got %0d want 2", got_r.size());
    end else begin
      checks++;
      if (got_r[0] !== rsp_t'({mem_rd(32'h3000), 1'b0, 1'b0})) begin
        errors++;
        $display("FAIL to_rsp0: got rdata=%h err=%b last=%b want %h 0 0",
                 got_r[0].rdata, got_r[0].err, got_r[0].last, mem_rd(32'h3000));
      end
      checks++;
      if (got_r[1] !== rsp_t'({32'h0, 1'b1, 1'b1})) begin
        errors++;
        $display("FAIL to_rsp_abort: got rdata=%h err=%b last=%b want 0 1 1",
                 got_r[1].rdata, got_r[1].err, got_r[1].last);
      end
    end
  endtask

  task automatic test_timeout_boundary();
    cmd_t c;
    for (int k = 0; k < 2; k++) begin
      c = '{write: 1'(k), addr: 32'h4000, wdata: 32'h1357_9BDF, byte_en: 4'h3, len: 8'd0};
      waits_m = '{TO - 1 + k};
      run_cmd(c, 0, 0);
      checks++;
      if (got_r.size() != 1 || got_r[0] !== exp_r[0] || bus_cyc != TO) begin
        errors++;
        $display("FAIL to_edge%0d: got %0d rsp (err=%b) over %0d cycles want 1 rsp (err=%b) over %0d",
                 k, got_r.size(), (got_r.size() > 0) ? got_r[0].err : 1'bx, bus_cyc, exp_r[0].err, TO);
      end
    end
  endtask

  task automatic test_addr_wrap();
    cmd_t c;
    c = '{write: 1'b0, addr: 32'hFFFF_FFFC, wdata: 32'h0, byte_en: 4'hF, len: 8'd1};
    waits_m = '{0, 1};
    run_cmd(c, 0, 0);
    checks++;
    if (got_b.size() != 2) begin
      errors++;
      $display("FAIL wrap_beats: got %0d want 2", got_b.size());
    end else begin
      checks++;
      if (got_b[1].addr !== 32'h0 || got_b[0].addr !== 32'hFFFF_FFFC) begin
        errors++;
        $display("FAIL wrap_addr: got %h,%h want fffffffc,00000000", got_b[0].addr, got_b[1].addr);
      end
    end
    checks++;
    if (got_r.size() != 2 || got_r[1] !== rsp_t'({mem_rd(32'h0), 1'b0, 1'b1})) begin
      errors++;
      $display("FAIL wrap_rsp: got %0d responses want 2 ending with rdata=%h last 1", got_r.size(), mem_rd(32'h0));
    end
  endtask

  task automatic test_reset_mid_burst();
    int n;
    got_b.delete();
    got_r.delete();
    wait_q = '{0, 3, 0, 0, 0, 0};
    bp_delay = 0;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h500; cmd_wdata = 32'h0F0F_0F0F;
    cmd_byte_en = 4'hC; cmd_len = 8'd5;
    @(posedge CLK);
    #1 cmd_valid = 1'b0;
    n = 0;
    while (got_b.size() < 1 && n < 50) begin
      @(negedge CLK);
      n++;
    end
    @(negedge CLK);
    checks++;
    if (gbus.wen !== 1'b1 || got_b.size() != 1) begin
      errors++;
      $display("FAIL rst_mid_setup: got wen=%b beats=%0d want 1, 1", gbus.wen, got_b.size());
    end
    RST = 1'b1;
    @(negedge CLK);
    checks++;
    if ({gbus.wen, gbus.ren, rsp_valid, cmd_ready} !== 4'b0 || gbus.addr !== 32'h0) begin
      errors++;
      $display("FAIL rst_mid_quiet: got wen,ren,vld,rdy=%b addr=%h want 0000 0",
               {gbus.wen, gbus.ren, rsp_valid, cmd_ready}, gbus.addr);
    end
    RST = 1'b0;
    @(negedge CLK);
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_ready: got %b want 1", cmd_ready);
    end
    repeat (5) @(negedge CLK);
    checks++;
    if (got_r.size() != 0 || got_b.size() != 1) begin
      errors++;
      $display("FAIL rst_mid_abandon: got %0d responses, %0d beats want 0, 1", got_r.size(), got_b.size());
    end
  endtask

  task automatic test_random();
    cmd_t c;
    int len;
    bit junk;
    for (int k = 0; k < 25; k++) begin
      len = $urandom_range(0, 5);
      c.write   = 1'($urandom_range(0, 1));
      c.addr    = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 : ($urandom() & 32'hFFFF_FFFC);
      c.wdata   = $urandom();
      c.byte_en = 4'($urandom_range(0, 15));
      c.len     = 8'(len);
      waits_m.delete();
      for (int b = 0; b <= len; b++) waits_m.push_back($urandom_range(0, 3));
      if ($urandom_range(0, 4) == 0) waits_m[$urandom_range(0, len)] = TO + $urandom_range(0, 2);
      junk = 1'($urandom_range(0, 1));
      run_cmd(c, $urandom_range(0, 3), junk);
      checks++;
      if (got_b.size() != exp_b.size() || got_r.size() != exp_r.size()) begin
        errors++;
        $display("FAIL rnd%0d_counts: got %0d beats %0d rsps want %0d beats %0d rsps",
                 k, got_b.size(), got_r.size(), exp_b.size(), exp_r.size());
      end
      for (int i = 0; i < exp_b.size() && i < got_b.size(); i++) begin
        checks++;
        if (got_b[i] !== exp_b[i]) begin
          errors++;
          $display("FAIL rnd%0d_beat[%0d]: got w=%b a=%h d=%h be=%h want w=%b a=%h d=%h be=%h", k, i,
                   got_b[i].write, got_b[i].addr, got_b[i].wdata, got_b[i].be,
                   exp_b[i].write, exp_b[i].addr, exp_b[i].wdata, exp_b[i].be);
        end
      end
      for (int i = 0; i < exp_r.size() && i < got_r.size(); i++) begin
        checks++;
        if (got_r[i] !== exp_r[i]) begin
          errors++;
          $display("FAIL rnd%0d_rsp[%0d]: got rdata=%h err=%b last=%b want rdata=%h err=%b last=%b", k, i,
                   got_r[i].rdata, got_r[i].err, got_r[i].last, exp_r[i].rdata, exp_r[i].err, exp_r[i].last);
        end
      end
      checks++;
      if (bus_cyc != exp_bus || both_hi != 0 || unstable != 0 || overlap != 0) begin
        errors++;
        $display("FAIL rnd%0d_bus: got cycles=%0d both=%0d unstable=%0d overlap=%0d want %0d,0,0,0",
                 k, bus_cyc, both_hi, unstable, overlap, exp_bus);
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    cmd_valid   = 1'b0;
    cmd_write   = 1'b0;
    cmd_addr    = 32'h0;
    cmd_wdata   = 32'h0;
    cmd_byte_en = 4'h0;
    cmd_len     = 8'h0;
    test_reset();
    test_single_read();
    test_write_fill();
    test_read_backpressure();
    test_timeout();
    test_timeout_boundary();
    test_addr_wrap();
    test_reset_mid_burst();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
